// File: rtl/lsu_pkg.sv
// lsu_pkg: size codes, MMIO offsets and FSM encoding shared by the load/store unit.
package lsu_pkg;
    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } size_e;

    localparam int OFF_OUT_LO = 0;
    localparam int OFF_OUT_HI = 4;
    localparam int OFF_IN     = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_e;
endpackage

// File: rtl/dmem_sp_ram.sv
// dmem_sp_ram: single-port synchronous RAM with byte write enables and 1-cycle read latency.
module dmem_sp_ram #(
    parameter int WORDS = 256,
    parameter int W     = 32
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [W/8-1:0]           be_i,
    input  logic [$clog2(WORDS)-1:0] addr_i,
    input  logic [W-1:0]             wdata_i,
    output logic [W-1:0]             rdata_o
);
    logic [W-1:0] mem_q [WORDS];

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < W/8; i++)
            if (we_i && be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        rdata_o <= mem_q[addr_i];
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: three-state load/store unit over a word-addressed DMEM plus three MMIO registers.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN              = 32,
    parameter int IO_INPUT_BUS_LEN  = 14,
    parameter int IO_OUTPUT_BUS_LEN = 52,
    parameter int IO_BASE_ADDR      = 712,
    parameter int DMEM_WORDS        = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_we,
    input  logic [2:0]                   req_size,
    input  logic [XLEN-1:0]              req_addr,
    input  logic [XLEN-1:0]              req_wdata,
    output logic                         rsp_valid,
    output logic [XLEN-1:0]              rsp_rdata,
    output logic                         rsp_err,
    input  logic [IO_INPUT_BUS_LEN-1:0]  io_input_bus,
    output logic [IO_OUTPUT_BUS_LEN-1:0] io_output_bus
);
    localparam int HI_W = IO_OUTPUT_BUS_LEN - 32;
    localparam int AW   = $clog2(DMEM_WORDS);
    localparam int NB   = XLEN / 8;
    localparam logic [XLEN-1:0] LO_A = XLEN'(IO_BASE_ADDR + OFF_OUT_LO);
    localparam logic [XLEN-1:0] HI_A = XLEN'(IO_BASE_ADDR + OFF_OUT_HI);
    localparam logic [XLEN-1:0] IN_A = XLEN'(IO_BASE_ADDR + OFF_IN);

    state_e                      state_q, state_d;
    logic                        we_q;
    logic [2:0]                  size_q;
    logic [XLEN-1:0]             addr_q, wdata_q;
    logic [31:0]                 out_lo_q;
    logic [HI_W-1:0]             out_hi_q;
    logic [IO_INPUT_BUS_LEN-1:0] sync1_q, sync2_q;
    logic [XLEN-1:0]             ram_rdata, wd, io_new, raw, sh, ld;
    logic [NB-1:0]               be;
    logic                        is_lo, is_hi, is_in, is_io, is_dmem, size_bad, misal, err, store;

    assign is_lo    = addr_q[XLEN-1:2] == LO_A[XLEN-1:2];
    assign is_hi    = addr_q[XLEN-1:2] == HI_A[XLEN-1:2];
    assign is_in    = addr_q[XLEN-1:2] == IN_A[XLEN-1:2];
    assign is_io    = is_lo || is_hi || is_in;
    assign is_dmem  = !is_io && addr_q < XLEN'(4 * DMEM_WORDS);
    assign size_bad = !(size_q == SZ_B || size_q == SZ_H || size_q == SZ_W ||
                        size_q == SZ_BU || size_q == SZ_HU);
    assign misal    = ((size_q == SZ_H || size_q == SZ_HU) && addr_q[0]) ||
                      (size_q == SZ_W && addr_q[1:0] != 2'b00);
    assign err      = size_bad || misal || !(is_io || is_dmem);
    // rst_n gates the store so a reset landing on ACCESS leaves DMEM untouched too
    assign store    = state_q == ST_ACCESS && we_q && !err && rst_n;

    assign be = size_q[1] ? '1 : size_q[0] ? NB'(2'b11) << addr_q[1:0] : NB'(1'b1) << addr_q[1:0];
    assign wd = size_q[1] ? wdata_q : size_q[0] ? {(XLEN/16){wdata_q[15:0]}} : {NB{wdata_q[7:0]}};

    always_comb begin
        io_new = is_hi ? XLEN'(out_hi_q) : XLEN'(out_lo_q);
        for (int i = 0; i < NB; i++)
            io_new[8*i +: 8] = be[i] ? wd[8*i +: 8] : io_new[8*i +: 8];
    end

    always_comb begin
        raw = is_lo ? XLEN'(out_lo_q) : is_hi ? XLEN'(out_hi_q) : is_in ? XLEN'(sync2_q) : ram_rdata;
        sh  = raw >> {addr_q[1:0], 3'b000};
        ld  = size_q == SZ_B  ? {{(XLEN-8){sh[7]}}, sh[7:0]} :
              size_q == SZ_H  ? {{(XLEN-16){sh[15]}}, sh[15:0]} :
              size_q == SZ_BU ? XLEN'(sh[7:0]) :
              size_q == SZ_HU ? XLEN'(sh[15:0]) : sh;
    end

    always_comb begin
        state_d = state_q;
        state_d = state_q == ST_IDLE   ? (req_valid ? ST_ACCESS : ST_IDLE) :
                  state_q == ST_ACCESS ? ST_RESP : ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            size_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            out_lo_q <= '0;
            out_hi_q <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
        end else begin
            state_q <= state_d;
            sync1_q <= io_input_bus;
            sync2_q <= sync1_q;
            if (state_q == ST_IDLE && req_valid) begin
                we_q    <= req_we;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (store && is_lo) out_lo_q <= io_new[31:0];
            if (store && is_hi) out_hi_q <= io_new[HI_W-1:0];
        end
    end

    dmem_sp_ram #(.WORDS(DMEM_WORDS), .W(XLEN)) u_dmem (
        .clk_i   (clk),
        .we_i    (store && is_dmem),
        .be_i    (be),
        .addr_i  (addr_q[AW+1:2]),
        .wdata_i (wd),
        .rdata_o (ram_rdata)
    );

    assign req_ready     = state_q == ST_IDLE;
    assign rsp_valid     = state_q == ST_RESP;
    assign rsp_err       = rsp_valid && err;
    assign rsp_rdata     = (rsp_valid && !we_q && !err) ? ld : '0;
    assign io_output_bus = {out_hi_q, out_lo_q};
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector table plus hand sequences for throughput, sync and reset abort.
module tb_load_store_unit;
    logic        clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_size = 3'b000;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [13:0] io_input_bus = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [51:0] io_output_bus;
    int          n_cmp = 0, n_bad = 0;

    typedef struct {
        logic        we;
        logic [2:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        er;
    } vec_t;
    vec_t v[$];

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .io_input_bus(io_input_bus), .io_output_bus(io_output_bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic access(input logic we, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er);
        int t = 0;
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("ready_wait", req_ready, 1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_addr = a; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0; req_we = ~we; req_size = 3'b111; req_addr = ~a; req_wdata = ~wd;
        check("rsp_n1", rsp_valid, 0);
        @(negedge clk);
        check("rsp_n2", rsp_valid, 1);
        rd = rsp_rdata;
        er = rsp_err;
        @(negedge clk);
        check("rsp_n3", rsp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_err", rsp_err, 0);
        check("rst_bus", io_output_bus, 0);

        v.push_back('{1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0});
        v.push_back('{1'b0, 3'b000, 32'h13,  32'h0,        32'hFFFFFFDE, 1'b0});
        v.push_back('{1'b0, 3'b100, 32'h13,  32'h0,        32'h000000DE, 1'b0});
        v.push_back('{1'b0, 3'b101, 32'h10,  32'h0,        32'h0000BEEF, 1'b0});
        v.push_back('{1'b0, 3'b001, 32'h12,  32'h0,        32'hFFFFDEAD, 1'b0});
        v.push_back('{1'b1, 3'b000, 32'h11,  32'h000000A5, 32'h0,        1'b0});
        v.push_back('{1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADA5EF, 1'b0});
        v.push_back('{1'b1, 3'b010, 32'd712, 32'h12345678, 32'h0,        1'b0});
        v.push_back('{1'b1, 3'b001, 32'd716, 32'h0000ABCD, 32'h0,        1'b0});
        v.push_back('{1'b0, 3'b010, 32'd716, 32'h0,        32'h0000ABCD, 1'b0});
        v.push_back('{1'b0, 3'b100, 32'd713, 32'h0,        32'h00000056, 1'b0});
        v.push_back('{1'b0, 3'b001, 32'd714, 32'h0,        32'h00001234, 1'b0});
        v.push_back('{1'b0, 3'b010, 32'h11,  32'h0,        32'h0,        1'b1});
        v.push_back('{1'b1, 3'b001, 32'h21,  32'h0000FFFF, 32'h0,        1'b1});
        v.push_back('{1'b0, 3'b010, 32'd1024,32'h0,        32'h0,        1'b1});
        v.push_back('{1'b1, 3'b010, 32'h12,  32'h11111111, 32'h0,        1'b1});
        v.push_back('{1'b1, 3'b011, 32'h10,  32'h22222222, 32'h0,        1'b1});
        v.push_back('{1'b0, 3'b010, 32'hFFFFFFFC, 32'h0,   32'h0,        1'b1});
        v.push_back('{1'b1, 3'b010, 32'd713, 32'hFFFFFFFF, 32'h0,        1'b1});
        v.push_back('{1'b1, 3'b010, 32'd720, 32'h00001234, 32'h0,        1'b0});
        v.push_back('{1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADA5EF, 1'b0});
        v.push_back('{1'b1, 3'b010, 32'h20,  32'h55AA55AA, 32'h0,        1'b0});
        v.push_back('{1'b0, 3'b010, 32'h20,  32'h0,        32'h55AA55AA, 1'b0});
        v.push_back('{1'b0, 3'b101, 32'h22,  32'h0,        32'h000055AA, 1'b0});
        v.push_back('{1'b1, 3'b010, 32'h3FC, 32'hCAFEF00D, 32'h0,        1'b0});
        v.push_back('{1'b0, 3'b010, 32'h3FC, 32'h0,        32'hCAFEF00D, 1'b0});

        foreach (v[i]) begin
            access(v[i].we, v[i].sz, v[i].a, v[i].wd, rd, er);
            check($sformatf("vec%0d_rdata", i), rd, v[i].rd);
            check($sformatf("vec%0d_err", i), er, v[i].er);
        end
        check("bus_after_table", io_output_bus, 52'h0ABCD12345678);

        io_input_bus = 14'h2A5A;
        repeat (3) @(negedge clk);
        access(1'b0, 3'b010, 32'd720, 32'h0, rd, er);
        check("in_lw", rd, 32'h00002A5A);
        access(1'b0, 3'b000, 32'd720, 32'h0, rd, er);
        check("in_lb", rd, 32'h0000005A);

        req_valid = 1'b1; req_we = 1'b0; req_size = 3'b010; req_addr = 32'h10;
        for (int k = 0; k < 9; k++) begin
            check($sformatf("hold%0d_ready", k), req_ready, (k % 3) == 0);
            check($sformatf("hold%0d_rsp", k), rsp_valid, (k % 3) == 2);
            if ((k % 3) == 2) check($sformatf("hold%0d_rdata", k), rsp_rdata, 32'hDEADA5EF);
            @(negedge clk);
        end
        req_valid = 1'b0;

        check("abort_pre_ready", req_ready, 1);
        req_valid = 1'b1; req_we = 1'b1; req_size = 3'b010; req_addr = 32'd712; req_wdata = 32'hFFFFFFFF;
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_rsp", rsp_valid, 0);
        check("abort_bus", io_output_bus, 0);
        check("abort_ready", req_ready, 1);
        @(negedge clk);
        check("abort_rsp_late", rsp_valid, 0);
        check("abort_bus_late", io_output_bus, 0);
        access(1'b0, 3'b010, 32'h10, 32'h0, rd, er);
        check("dmem_kept", rd, 32'hDEADA5EF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter IO_INPUT_BUS_LEN, default 14, input bus width.
REQ-003 SHALL have parameter IO_OUTPUT_BUS_LEN, default 52, output bus width.
REQ-004 SHALL have parameter IO_BASE_ADDR, default 712, byte address of first MMIO register.
REQ-005 SHALL have parameter DMEM_WORDS, default 256, data memory depth in XLEN-bit words.
REQ-006 SHALL use one clock and a synchronous, active-low reset.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst_n  input  1  synchronous, active-low reset.
REQ-009 req_valid  input  1  access request present.
REQ-010 req_ready  output  1  unit can accept a request.
REQ-011 req_we  input  1  1 = store, 0 = load.
REQ-012 req_size  input  3  funct3 code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-013 req_addr  input  XLEN  byte address from ALU result.
REQ-014 req_wdata  input  XLEN  store data, right-aligned.
REQ-015 rsp_valid  output  1  one-cycle response strobe.
REQ-016 rsp_rdata  output  XLEN  load result; 0 for stores and errors.
REQ-017 rsp_err  output  1  misaligned, out-of-range or illegal-size access.
REQ-018 io_input_bus  input  IO_INPUT_BUS_LEN  asynchronous external inputs.
REQ-019 io_output_bus  output  IO_OUTPUT_BUS_LEN  registered external outputs.

Function
REQ-020 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; req_ready=1 only in IDLE.
REQ-021 SHALL accept a request when req_valid && req_ready in cycle N and capture all req_* fields; rsp_valid SHALL be 1 for exactly cycle N+2.
REQ-022 SHALL ignore req_* fields while not in IDLE.
REQ-023 SHALL decode addresses as: IO_BASE_ADDR (OUT_LO, out bus bits 31:0); IO_BASE_ADDR+4 (OUT_HI, out bus bits 51:32); IO_BASE_ADDR+8 (IN, read-only). IO decode takes priority over DMEM.
REQ-024 SHALL decode as DMEM any other address < 4*DMEM_WORDS, word index addr[9:2]; all other addresses SHALL raise rsp_err.
REQ-025 SHALL flag rsp_err for H/HU with addr[0]=1, W with addr[1:0]!=0, or an undefined req_size; flagged accesses SHALL not modify DMEM or io_output_bus.
REQ-026 SHALL perform stores in ACCESS using byte enables derived from req_size and addr[1:0] (data replicated into the selected lanes).
REQ-027 SHALL apply the same byte enables to OUT_LO/OUT_HI; OUT_HI bits above IO_OUTPUT_BUS_LEN-32 SHALL be discarded.
REQ-028 SHALL silently drop stores to IN with rsp_err=0.
REQ-029 SHALL return loads as: B/H sign-extended, BU/HU zero-extended, W unmodified, each after a right shift by 8*addr[1:0].
REQ-030 SHALL read OUT_HI zero-extended above bit 19 and IN zero-extended above bit IO_INPUT_BUS_LEN-1.
REQ-031 SHALL pass io_input_bus through a 2-flop synchronizer; IN reads SHALL return the second-stage value.
REQ-032 SHALL give a DMEM read-after-write to the same word in back-to-back requests the new data (no hazard, because a store completes before the next acceptance).

Reset
REQ-033 SHALL, with rst_n=0 at a rising edge, force state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, io_output_bus=0 and synchronizer flops=0.
REQ-034 SHALL abort an in-flight access on reset: no response is issued, and a store in ACCESS during the reset cycle SHALL not update io_output_bus.
REQ-035 SHALL not reset DMEM contents.

Structure
REQ-036 SHALL place the size codes, MMIO offsets (OUT_LO=0, OUT_HI=4, IN=8) and FSM state encoding in the shared package lsu_pkg.
REQ-037 SHALL instantiate one sub-module, dmem_sp_ram: a single-port synchronous RAM with byte write enables and 1-cycle read latency, DMEM_WORDS x XLEN.

Verification
REQ-038 SW 0xDEADBEEF to 0x10, then LB at 0x13 -> rsp_rdata=0xFFFFFFDE; LBU at 0x13 -> 0x000000DE; LHU at 0x10 -> 0x0000BEEF.
REQ-039 SW 0x12345678 to 712, then SH 0xABCD to 716 -> io_output_bus=52'h0ABCD12345678; LW 716 -> 0x0000ABCD.
REQ-040 Drive io_input_bus=14'h2A5A; a LW at 720 accepted at least 2 cycles later -> 0x00002A5A.
REQ-041 LW at 0x11, SH at 0x21, and LW at 1024 -> rsp_err=1 and rsp_rdata=0 for each; DMEM and bus unchanged.
REQ-042 Hold req_valid=1 continuously -> acceptances every 3 cycles, rsp_valid exactly 2 cycles after each acceptance, req_ready=0 in between.
REQ-043 Assert rst_n=0 in the ACCESS cycle of SW 0xFFFFFFFF to 712 -> no rsp_valid, io_output_bus=0, req_ready=1 in the cycle after reset releases.
